// File: rtl/npu_fc_engine.sv
// rtl/npu_fc_engine.sv - memory-mapped 4-lane fully-connected layer engine with weight FIFO and argmax
module npu_fc_engine #(
    parameter int IN_N       = 132,
    parameter int OUT_M      = 10,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        ena,
    input  logic        wea,
    input  logic [15:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta
);
    localparam int WPN = (IN_N + 3) / 4;
    localparam int WW  = (WPN > 1) ? $clog2(WPN) : 1;
    localparam int MW  = (OUT_M > 1) ? $clog2(OUT_M) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int PADN = 4 * (2 ** WW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [2:0]              sel;
    logic [11:0]             idx;
    logic                    addr_unused;
    logic                    wr_en, rd_en, cmd_wr, start, soft_clear, push, in_wr;

    assign sel         = addra[14:12];
    assign idx         = addra[11:0];
    assign addr_unused = addra[15];
    assign wr_en       = ena & wea;
    assign rd_en       = ena & ~wea;
    assign cmd_wr      = wr_en && (sel == 3'b101) && (idx == 12'd0);
    assign soft_clear  = cmd_wr & dina[1];
    assign start       = cmd_wr & dina[0] & ~dina[1];
    assign push        = wr_en && (sel == 3'b010);
    assign in_wr       = wr_en && (sel == 3'b001) && (state != RUN);

    logic [7:0] in_vec [IN_N];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < IN_N; b++) in_vec[b] <= '0;
        end else if (in_wr) begin
            for (int b = 0; b < IN_N; b++)
                if (idx == 12'(b / 4)) in_vec[b] <= dina[8*(b%4) +: 8];
        end
    end

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, overflow, pop, push_ok;

    // Fullness is judged before any same-cycle pop, so a push to a full FIFO drops.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop     = (state == RUN) & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= dina;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (soft_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push & full) overflow <= 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    logic [7:0]              in_pad [PADN];
    logic [31:0]             wword;
    logic [WW-1:0]           w;
    logic [MW-1:0]           m, argmax;
    logic signed [16:0]      prod [4];
    logic signed [ACC_W-1:0] acc, acc_next, res_next, best, lane_sum;
    logic signed [ACC_W-1:0] result [OUT_M];
    logic                    done, relu_en;

    assign wword = fifo_mem[rd_ptr];

    // Lanes past IN_N see a zero input byte, so padding weights never contribute.
    always_comb begin
        for (int i = 0; i < PADN; i++) in_pad[i] = 8'd0;
        for (int i = 0; i < IN_N; i++) in_pad[i] = in_vec[i];
        lane_sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k]  = $signed(wword[8*k +: 8]) * $signed({1'b0, in_pad[{w, 2'(k)}]});
            lane_sum = lane_sum + ACC_W'(prod[k]);
        end
        acc_next = acc + lane_sum;
        res_next = (relu_en && acc_next[ACC_W-1]) ? '0 : acc_next;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            acc     <= '0;
            m       <= '0;
            w       <= '0;
            best    <= '0;
            argmax  <= '0;
            done    <= 1'b0;
            relu_en <= 1'b0;
            for (int i = 0; i < OUT_M; i++) result[i] <= '0;
        end else if (soft_clear) begin
            state   <= IDLE;
            acc     <= '0;
            m       <= '0;
            w       <= '0;
            best    <= '0;
            argmax  <= '0;
            done    <= 1'b0;
            for (int i = 0; i < OUT_M; i++) result[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        done    <= 1'b0;
                        acc     <= '0;
                        m       <= '0;
                        w       <= '0;
                        best    <= '0;
                        argmax  <= '0;
                        relu_en <= dina[2];
                    end
                end
                RUN: begin
                    if (!empty) begin
                        if (w == WW'(WPN - 1)) begin
                            result[m] <= res_next;
                            if ((m == '0) || (res_next > best)) begin
                                best   <= res_next;
                                argmax <= m;
                            end
                            acc <= '0;
                            w   <= '0;
                            if (m == MW'(OUT_M - 1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                                m     <= '0;
                            end else begin
                                m <= m + MW'(1);
                            end
                        end else begin
                            acc <= acc_next;
                            w   <= w + WW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (sel == 3'b111) begin
            case (idx)
                12'd0:   rd_data = {27'd0, overflow, full, empty, (state == RUN), done};
                12'd1:   rd_data = 32'(count);
                12'd2:   rd_data = 32'(argmax);
                default: begin
                    for (int i = 0; i < OUT_M; i++)
                        if (idx == 12'(256 + i)) rd_data = 32'(result[i]);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) douta <= '0;
        else if (rd_en) douta <= rd_data;
    end
endmodule

// File: tb/tb_npu_fc_engine.sv
// tb/tb_npu_fc_engine.sv - randomized self-checking bench for npu_fc_engine against a dot-product model
module tb_npu_fc_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta_a, douta_b, douta_c, douta;
    int          dsel;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    npu_fc_engine #(.IN_N(8), .OUT_M(2), .ACC_W(24), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_ni(rst_n), .ena(ena && dsel == 0), .wea(wea),
        .addra(addra), .dina(dina), .douta(douta_a));
    npu_fc_engine #(.IN_N(132), .OUT_M(10), .ACC_W(24), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst_ni(rst_n), .ena(ena && dsel == 1), .wea(wea),
        .addra(addra), .dina(dina), .douta(douta_b));
    npu_fc_engine #(.IN_N(5), .OUT_M(3), .ACC_W(24), .FIFO_DEPTH(8)) dut_c (
        .clk(clk), .rst_ni(rst_n), .ena(ena && dsel == 2), .wea(wea),
        .addra(addra), .dina(dina), .douta(douta_c));

    always_comb douta = (dsel == 0) ? douta_a : (dsel == 1) ? douta_b : douta_c;

    logic [7:0] x [0:135];
    logic [7:0] wt [0:9][0:135];
    int         exp_res [0:9];
    int         exp_arg;

    // Reference: plain dot product over the first in_n bytes, 24-bit wrap, optional ReLU, first max wins.
    function automatic void model(input int in_n, input int out_m, input bit relu);
        longint acc;
        for (int mm = 0; mm < out_m; mm++) begin
            acc = 0;
            for (int j = 0; j < in_n; j++)
                acc += longint'($signed(wt[mm][j])) * longint'(x[j]);
            acc = acc & 64'hFFFFFF;
            if (acc >= 64'h800000) acc -= 64'h1000000;
            if (relu && acc < 0) acc = 0;
            exp_res[mm] = int'(acc);
        end
        exp_arg = 0;
        for (int mm = 1; mm < out_m; mm++)
            if (exp_res[mm] > exp_res[exp_arg]) exp_arg = mm;
    endfunction

    task automatic wr(input logic [2:0] s, input logic [11:0] i, input logic [31:0] d);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = {1'b0, s, i}; dina = d;
        @(posedge clk);
        #1 ena = 1'b0; wea = 1'b0;
    endtask

    task automatic rd(input logic [2:0] s, input logic [11:0] i, output logic [31:0] d);
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = {1'b0, s, i};
        @(posedge clk);
        #1 ena = 1'b0;
        d = douta;
    endtask

    task automatic fill_rand(input int in_n, input int out_m);
        for (int j = 0; j < 136; j++) x[j] = 8'($urandom);
        for (int mm = 0; mm < out_m; mm++)
            for (int j = 0; j < 136; j++) wt[mm][j] = 8'($urandom);
    endtask

    task automatic load_input(input int in_n);
        for (int ww = 0; ww < (in_n + 3) / 4; ww++)
            wr(3'b001, 12'(ww), {x[4*ww+3], x[4*ww+2], x[4*ww+1], x[4*ww]});
    endtask

    task automatic push_all(input int in_n, input int out_m);
        for (int mm = 0; mm < out_m; mm++)
            for (int ww = 0; ww < (in_n + 3) / 4; ww++)
                wr(3'b010, 12'd0, {wt[mm][4*ww+3], wt[mm][4*ww+2], wt[mm][4*ww+1], wt[mm][4*ww]});
    endtask

    task automatic wait_done(input string tag, output int polls);
        logic [31:0] d;
        polls = 0;
        for (int p = 1; p <= 2000; p++) begin
            rd(3'b111, 12'd0, d);
            if (d[0]) begin
                polls = p;
                break;
            end
        end
        if (polls == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s done_timeout: got done=0 want done=1 within 2000 polls", tag);
        end
    endtask

    task automatic check_results(input string tag, input int out_m);
        logic [31:0] d;
        for (int mm = 0; mm < out_m; mm++) begin
            rd(3'b111, 12'(256 + mm), d);
            n_cmp++;
            if (d !== 32'(exp_res[mm])) begin
                n_err++;
                $display("FAIL %s result[%0d]: got %h want %h", tag, mm, d, 32'(exp_res[mm]));
            end
        end
        rd(3'b111, 12'd2, d);
        n_cmp++;
        if (d !== 32'(exp_arg)) begin
            n_err++;
            $display("FAIL %s argmax: got %0d want %0d", tag, d, exp_arg);
        end
        rd(3'b111, 12'd0, d);
        n_cmp++;
        if (d !== 32'h5) begin
            n_err++;
            $display("FAIL %s status_done: got %h want %h", tag, d, 32'h5);
        end
    endtask

    task automatic run(input string tag, input int in_n, input int out_m, input bit relu);
        int polls;
        wr(3'b101, 12'd0, {29'd0, relu, 2'b01});
        push_all(in_n, out_m);
        wait_done(tag, polls);
        check_results(tag, out_m);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_cmp++;
        if (douta_a !== 32'd0 || douta_b !== 32'd0 || douta_c !== 32'd0) begin
            n_err++;
            $display("FAIL reset_douta: got %h/%h/%h want 0", douta_a, douta_b, douta_c);
        end
        dsel = 0;
        rd(3'b111, 12'd0, d);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL reset_status: got %h want 4", d); end
        rd(3'b111, 12'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", d); end
        rd(3'b111, 12'd0, d);
        rd(3'b111, 12'h102, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL result_oob_read: got %h want 0", d); end
        rd(3'b111, 12'd1, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", d); end
        rd(3'b111, 12'h101, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_result1: got %h want 0", d); end
    endtask

    task automatic set_basic(input logic [7:0] w1);
        for (int j = 0; j < 8; j++) begin
            x[j]     = 8'(j + 1);
            wt[0][j] = 8'h01;
            wt[1][j] = w1;
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int polls;
        dsel = 0;
        set_basic(8'hFF);
        load_input(8);
        push_all(8, 2);
        rd(3'b111, 12'd1, d);
        n_cmp++;
        if (d !== 32'd4) begin n_err++; $display("FAIL prefill_count: got %0d want 4", d); end
        wr(3'b101, 12'd0, 32'h1);
        wait_done("basic", polls);
        n_cmp++;
        if (polls != 2 * 2 + 1) begin
            n_err++;
            $display("FAIL done_latency: got poll %0d want %0d", polls, 2 * 2 + 1);
        end
        exp_res[0] = 36; exp_res[1] = -36; exp_arg = 0;
        check_results("basic", 2);
    endtask

    task automatic test_relu();
        dsel = 0;
        set_basic(8'hFF);
        exp_res[0] = 36; exp_res[1] = 0; exp_arg = 0;
        run("relu_clamp", 8, 2, 1'b1);
        set_basic(8'h02);
        exp_res[0] = 36; exp_res[1] = 72; exp_arg = 1;
        run("relu_pos", 8, 2, 1'b1);
    endtask

    task automatic test_stall();
        logic [31:0] d;
        int polls;
        dsel = 0;
        set_basic(8'hFF);
        load_input(8);
        wr(3'b101, 12'd0, 32'h1);
        repeat (2) @(posedge clk);
        rd(3'b111, 12'd0, d);
        n_cmp++;
        if (d !== 32'h6) begin n_err++; $display("FAIL stall_status: got %h want 6", d); end
        for (int i = 0; i < 4; i++) begin
            wr(3'b010, 12'd0, {wt[i/2][4*(i%2)+3], wt[i/2][4*(i%2)+2], wt[i/2][4*(i%2)+1], wt[i/2][4*(i%2)]});
            if (i == 1) begin
                wr(3'b101, 12'd0, 32'h1);
            end else begin
                rd(3'b111, 12'd0, d);
                n_cmp++;
                if (d[1:0] !== 2'b10) begin
                    n_err++;
                    $display("FAIL stall_busy[%0d]: got %b want 10", i, d[1:0]);
                end
            end
            if (i == 2) wr(3'b001, 12'd0, 32'hDEADBEEF);
            else @(posedge clk);
        end
        wait_done("stall", polls);
        exp_res[0] = 36; exp_res[1] = -36; exp_arg = 0;
        check_results("stall", 2);
    endtask

    task automatic test_random_a();
        bit relu;
        dsel = 0;
        for (int it = 0; it < 4; it++) begin
            fill_rand(8, 2);
            relu = 1'($urandom_range(0, 1));
            load_input(8);
            model(8, 2, relu);
            run("rand_a", 8, 2, relu);
        end
    endtask

    task automatic test_default();
        dsel = 1;
        fill_rand(132, 10);
        load_input(132);
        model(132, 10, 1'b0);
        run("default", 132, 10, 1'b0);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        dsel = 1;
        for (int i = 0; i < 10; i++) wr(3'b010, 12'd0, $urandom);
        rd(3'b111, 12'd1, d);
        n_cmp++;
        if (d !== 32'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", d); end
        rd(3'b111, 12'd0, d);
        n_cmp++;
        if (d !== 32'h19) begin n_err++; $display("FAIL ovf_status: got %h want 19", d); end
        wr(3'b101, 12'd0, 32'h3);
        rd(3'b111, 12'd0, d);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL clr_status: got %h want 4", d); end
        rd(3'b111, 12'd1, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", d); end
        rd(3'b111, 12'h103, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL clr_result3: got %h want 0", d); end
        rd(3'b111, 12'd2, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL clr_argmax: got %0d want 0", d); end
        for (int mm = 0; mm < 10; mm++)
            for (int j = 0; j < 132; j++) wt[mm][j] = 8'($urandom);
        model(132, 10, 1'b1);
        run("retained_input", 132, 10, 1'b1);
    endtask

    task automatic test_padding();
        bit relu;
        dsel = 2;
        fill_rand(5, 3);
        x[5] = 8'h7F; x[6] = 8'h7F; x[7] = 8'h7F;
        for (int mm = 0; mm < 3; mm++)
            for (int j = 0; j < 8; j++) wt[mm][j] = 8'h7F;
        load_input(5);
        model(5, 3, 1'b0);
        run("padding", 5, 3, 1'b0);
        for (int it = 0; it < 3; it++) begin
            fill_rand(5, 3);
            relu = 1'($urandom_range(0, 1));
            load_input(5);
            model(5, 3, relu);
            run("rand_c", 5, 3, relu);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        dsel = 0;
        fill_rand(8, 2);
        wt[0][0] = 8'h40; x[0] = 8'hFF;
        for (int j = 1; j < 8; j++) wt[0][j] = 8'h00;
        load_input(8);
        model(8, 2, 1'b0);
        wr(3'b101, 12'd0, 32'h1);
        wr(3'b010, 12'd0, {wt[0][3], wt[0][2], wt[0][1], wt[0][0]});
        wr(3'b010, 12'd0, {wt[0][7], wt[0][6], wt[0][5], wt[0][4]});
        @(posedge clk);
        rd(3'b111, 12'h100, d);
        n_cmp++;
        if (d !== 32'(exp_res[0])) begin
            n_err++;
            $display("FAIL midrun_result0: got %h want %h", d, 32'(exp_res[0]));
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (douta !== 32'd0) begin n_err++; $display("FAIL rst_douta: got %h want 0", douta); end
        #3 rst_n = 1'b1;
        rd(3'b111, 12'd0, d);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL rst_status: got %h want 4", d); end
        rd(3'b111, 12'h100, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL rst_result0: got %h want 0", d); end
        fill_rand(8, 2);
        load_input(8);
        model(8, 2, 1'b0);
        run("after_reset", 8, 2, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; dsel = 0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_relu();
        test_stall();
        test_random_a();
        test_default();
        test_overflow();
        test_padding();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
